// File: rtl/window_sum_acc_pkg.sv
// Shared definitions for the window-sum stage: sample width, upstream select
// encodings, window FSM states and a reusable saturating narrow function.
package window_sum_acc_pkg;

    localparam int DIN_W_DEF = 9;
    localparam int ACC_W_DEF = 12;
    localparam int OUT_W_DEF = 10;

    // Upstream ALU/select opcodes; a stream of their results feeds this stage.
    localparam logic [1:0] SEL_A   = 2'b00;
    localparam logic [1:0] SEL_B   = 2'b01;
    localparam logic [1:0] SEL_ADD = 2'b10;
    localparam logic [1:0] SEL_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic [OUT_W_DEF-1:0] sat_signed(input logic signed [ACC_W_DEF-1:0] v);
        logic [ACC_W_DEF-OUT_W_DEF:0] hi;
        hi = v[ACC_W_DEF-1:OUT_W_DEF-1];
        if (!v[ACC_W_DEF-1] && (|hi))
            sat_signed = {1'b0, {(OUT_W_DEF-1){1'b1}}};
        else if (v[ACC_W_DEF-1] && !(&hi))
            sat_signed = {1'b1, {(OUT_W_DEF-1){1'b0}}};
        else
            sat_signed = v[OUT_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/window_sum_acc_sat_clip.sv
// Combinational signed saturator: narrows IN_W to OUT_W, clipping to the
// extreme representable values and flagging when clipping happened.
module window_sum_acc_sat_clip #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 10
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_val,
    output logic                    o_sat
);

    generate
        if (IN_W > OUT_W) begin : g_narrow
            // Value fits iff every bit from the sign down to bit OUT_W-1 agrees.
            logic w_pos_ovf;
            logic w_neg_ovf;
            assign w_pos_ovf = !i_val[IN_W-1] && (|i_val[IN_W-2:OUT_W-1]);
            assign w_neg_ovf =  i_val[IN_W-1] && !(&i_val[IN_W-2:OUT_W-1]);
            assign o_sat     = w_pos_ovf | w_neg_ovf;
            assign o_val     = w_pos_ovf ? {1'b0, {(OUT_W-1){1'b1}}} :
                               w_neg_ovf ? {1'b1, {(OUT_W-1){1'b0}}} :
                               i_val[OUT_W-1:0];
        end else begin : g_widen
            assign o_val = OUT_W'(i_val);
            assign o_sat = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/window_sum_acc.sv
// Sums a valid-qualified signed sample stream over non-overlapping windows of
// N samples and presents each saturated total behind a valid/ready handshake.
module window_sum_acc
    import window_sum_acc_pkg::*;
#(
    parameter int DIN_W = DIN_W_DEF,
    parameter int N     = 8,
    parameter int OUT_W = 10,
    localparam int CNT_W = $clog2(N),
    localparam int ACC_W = DIN_W + CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic signed [DIN_W-1:0] din,
    input  logic                    din_vld,
    output logic                    din_rdy,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_sat,
    output logic                    dout_vld,
    input  logic                    dout_rdy,
    output logic [CNT_W-1:0]        win_cnt,
    output logic [1:0]              dbg_state
);

    // Handshake rules: a sample is taken when din_vld & din_rdy; a result
    // leaves when dout_vld & dout_rdy. din_rdy drops only while a result is
    // held and downstream stalls, so a pending result is never overwritten.

    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_win_cnt;
    logic signed [OUT_W-1:0] r_dout;
    logic                    r_dout_sat;
    logic                    r_dout_vld;
    state_t                  r_state;

    logic                    w_acc_in;
    logic                    w_take;
    logic                    w_xfer;
    logic                    w_last;
    logic                    w_complete;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [OUT_W-1:0] w_sat_val;
    logic                    w_sat_flag;
    logic                    w_nxt_vld;
    logic [CNT_W-1:0]        w_nxt_cnt;

    assign din_rdy    = !r_dout_vld | dout_rdy;
    assign w_acc_in   = din_vld & din_rdy;
    assign w_take     = w_acc_in & !clr;
    assign w_xfer     = r_dout_vld & dout_rdy;
    assign w_last     = (r_win_cnt == CNT_W'(N - 1));
    assign w_complete = w_take & w_last;
    assign w_sum      = r_acc + ACC_W'(din);

    window_sum_acc_sat_clip #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat_clip (
        .i_val (w_sum),
        .o_val (w_sat_val),
        .o_sat (w_sat_flag)
    );

    assign w_nxt_vld = w_complete | (r_dout_vld & !w_xfer);

    always_comb begin
        w_nxt_cnt = r_win_cnt;
        if (clr)
            w_nxt_cnt = '0;
        else if (w_take)
            w_nxt_cnt = w_last ? '0 : r_win_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_win_cnt  <= '0;
            r_dout     <= '0;
            r_dout_sat <= 1'b0;
            r_dout_vld <= 1'b0;
            r_state    <= ST_IDLE;
        end else begin
            r_win_cnt  <= w_nxt_cnt;
            r_dout_vld <= w_nxt_vld;
            if (clr || w_complete)
                r_acc <= '0;
            else if (w_take)
                r_acc <= w_sum;
            if (w_complete) begin
                r_dout     <= w_sat_val;
                r_dout_sat <= w_sat_flag;
            end
            // HOLD tracks the output register; a partial window may run under it.
            if (w_nxt_vld)
                r_state <= ST_HOLD;
            else if (w_nxt_cnt != '0)
                r_state <= ST_ACC;
            else
                r_state <= ST_IDLE;
        end
    end

    assign dout      = r_dout;
    assign dout_sat  = r_dout_sat;
    assign dout_vld  = r_dout_vld;
    assign win_cnt   = r_win_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_window_sum_acc.sv
// Directed self-checking bench for window_sum_acc with hand-computed window totals.
module tb_window_sum_acc;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic signed [8:0] din;
    logic              din_vld;
    logic              din_rdy;
    logic signed [9:0] dout;
    logic              dout_sat;
    logic              dout_vld;
    logic              dout_rdy;
    logic [2:0]        win_cnt;
    logic [1:0]        dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    window_sum_acc #(.DIN_W(9), .N(8), .OUT_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .din       (din),
        .din_vld   (din_vld),
        .din_rdy   (din_rdy),
        .dout      (dout),
        .dout_sat  (dout_sat),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .win_cnt   (win_cnt),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Eight samples of one value, then one idle cycle; returns just after the
    // edge that registered the window result.
    task automatic drive_window(input int v);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            din     = 9'(v);
            din_vld = 1'b1;
        end
        @(negedge clk);
        din_vld = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        din      = '0;
        din_vld  = 1'b0;
        dout_rdy = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_dout_sat", dout_sat, 0);
        chk("rst_dout_vld", dout_vld, 0);
        chk("rst_win_cnt", win_cnt, 0);
        chk("rst_din_rdy", din_rdy, 1);
        chk("rst_state", dbg_state, 0);
        rst_n = 1'b1;

        // Basic sum 1..8 = 36
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 4) begin
                chk("basic_win_cnt3", win_cnt, 3);
                chk("basic_state_acc", dbg_state, 1);
                chk("basic_vld_low", dout_vld, 0);
            end
            din     = 9'(i);
            din_vld = 1'b1;
        end
        @(negedge clk);
        din_vld = 1'b0;
        chk("basic_dout", dout, 36);
        chk("basic_sat", dout_sat, 0);
        chk("basic_vld", dout_vld, 1);
        chk("basic_win_cnt0", win_cnt, 0);
        chk("basic_state_hold", dbg_state, 2);
        @(negedge clk);
        chk("basic_vld_one_cycle", dout_vld, 0);
        chk("basic_dout_hold", dout, 36);
        chk("basic_state_idle", dbg_state, 0);

        // Positive saturation, then a normal negative window
        drive_window(255);
        chk("possat_dout", dout, 511);
        chk("possat_sat", dout_sat, 1);
        chk("possat_vld", dout_vld, 1);
        drive_window(-3);
        chk("neg24_dout", dout, -24);
        chk("neg24_sat", dout_sat, 0);

        // Negative saturation
        drive_window(-256);
        chk("negsat_dout", dout, -512);
        chk("negsat_sat", dout_sat, 1);

        // Backpressure: window of 7s completes with downstream stalled
        @(negedge clk);
        dout_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            din     = 9'sd7;
            din_vld = 1'b1;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_din_rdy", din_rdy, 0);
            chk("bp_dout", dout, 56);
            chk("bp_vld", dout_vld, 1);
            chk("bp_win_cnt", win_cnt, 0);
        end
        dout_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", din_rdy, 1);
        @(negedge clk);
        chk("bp_next_win_cnt", win_cnt, 1);
        chk("bp_vld_drop", dout_vld, 0);
        for (int i = 0; i < 6; i++) @(negedge clk);
        din     = 9'sd1;
        @(negedge clk);
        din_vld = 1'b0;
        chk("bp_second_window", dout, 50);

        // Clear mid-window drops the partial sum and the same-cycle sample
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            din     = 9'sd10;
            din_vld = 1'b1;
        end
        @(negedge clk);
        chk("clr_pre_cnt", win_cnt, 3);
        clr = 1'b1;
        @(negedge clk);
        clr     = 1'b0;
        din_vld = 1'b0;
        chk("clr_win_cnt", win_cnt, 0);
        drive_window(1);
        chk("clr_dout", dout, 8);

        // Asynchronous reset mid-window
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            din     = 9'sd3;
            din_vld = 1'b1;
        end
        @(negedge clk);
        din_vld = 1'b0;
        chk("rstmid_pre_cnt", win_cnt, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_win_cnt", win_cnt, 0);
        chk("rstmid_dout", dout, 0);
        chk("rstmid_vld", dout_vld, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_window(2);
        chk("rstmid_after_dout", dout, 16);
        chk("rstmid_after_vld", dout_vld, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
